// File: rtl/fetch_decode_buffer_pkg.sv
// Shared definitions for the IF->ID buffer: bus widths and a parameter sanity helper.
package fetch_decode_buffer_pkg;

    localparam int ADDR_BUS_WIDTH = 32;
    localparam int INST_BUS_WIDTH = 32;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_decode_buffer_storage.sv
// fdb_storage: DEPTH-entry register array, synchronous write, asynchronous read,
// synchronous active-low zeroing reset.
module fdb_storage #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF->ID boundary FIFO of (addr, inst) pairs with valid/ready handshakes and flush.
// Optional same-cycle pass-through on an empty buffer when FDB_BYPASS_EN is defined.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS_WIDTH,
    parameter int INST_WIDTH = INST_BUS_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       valid_in,
    input  logic [ADDR_WIDTH-1:0]      addr_in,
    input  logic [INST_WIDTH-1:0]      inst_in,
    output logic                       ready_out,
    output logic                       valid_out,
    output logic [ADDR_WIDTH-1:0]      addr_out,
    output logic [INST_WIDTH-1:0]      inst_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int DW = ADDR_WIDTH + INST_WIDTH;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IW] != r_rd_ptr[IW]) &&
                     (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);

`ifdef FDB_BYPASS_EN
    assign w_bypass = w_empty & valid_in & ready_in & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed pair is consumed directly by decode, so it is never stored.
    assign w_push = valid_in & ~w_full & ~flush & ~w_bypass;
    assign w_pop  = ~w_empty & ready_in & ~flush;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    fdb_storage #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[IW-1:0]),
        .i_wdata ({addr_in, inst_in}),
        .i_raddr (r_rd_ptr[IW-1:0]),
        .o_rdata (w_head)
    );

    assign ready_out = ~w_full;
    assign count     = r_wr_ptr - r_rd_ptr;

    always_comb begin
        valid_out = ~w_empty;
        addr_out  = w_head[DW-1:INST_WIDTH];
        inst_out  = w_head[INST_WIDTH-1:0];
        if (w_bypass) begin
            valid_out = 1'b1;
            addr_out  = addr_in;
            inst_out  = inst_in;
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer at DEPTH = 2.
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic [31:0] addr_in;
    logic [31:0] inst_in;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] addr_out;
    logic [31:0] inst_out;
    logic        ready_in;
    logic [1:0]  count;

    int checks   = 0;
    int failures = 0;

    fetch_decode_buffer #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .DEPTH      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .valid_in  (valid_in),
        .addr_in   (addr_in),
        .inst_in   (inst_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .addr_out  (addr_out),
        .inst_out  (inst_out),
        .ready_in  (ready_in),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i);
        valid_in = v;
        addr_in  = a;
        inst_in  = i;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; ready_in = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        tick();
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
        checks++;
        if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ready_out); end
        checks++;
        if (addr_out !== 32'h0 || inst_out !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h/%h exp=0/0", addr_out, inst_out);
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_fill();
        ready_in = 1'b0;
        drive(1'b1, 32'hBFC0_0000, 32'h2408_0001);
        tick();
        checks++;
        if (count !== 2'd1 || valid_out !== 1'b1 || addr_out !== 32'hBFC0_0000) begin
            failures++; $display("FAIL fill_first got=cnt%0d v%0b %h exp=cnt1 v1 bfc00000", count, valid_out, addr_out);
        end
        drive(1'b1, 32'hBFC0_0004, 32'h2409_0002);
        tick();
        checks++;
        if (count !== 2'd2 || ready_out !== 1'b0) begin
            failures++; $display("FAIL fill_full got=cnt%0d rdy%0b exp=cnt2 rdy0", count, ready_out);
        end
        drive(1'b1, 32'hBFC0_0008, 32'h240A_0003);
        tick();
        checks++;
        if (count !== 2'd2 || addr_out !== 32'hBFC0_0000 || inst_out !== 32'h2408_0001) begin
            failures++; $display("FAIL fill_refuse got=cnt%0d %h/%h exp=cnt2 bfc00000/24080001", count, addr_out, inst_out);
        end
    endtask

    task automatic test_drain();
        drive(1'b0, 32'h0, 32'h0);
        ready_in = 1'b1;
        #1;
        checks++;
        if (addr_out !== 32'hBFC0_0000 || valid_out !== 1'b1) begin
            failures++; $display("FAIL drain_head0 got=v%0b %h exp=v1 bfc00000", valid_out, addr_out);
        end
        tick();
        checks++;
        if (addr_out !== 32'hBFC0_0004 || inst_out !== 32'h2409_0002 || count !== 2'd1) begin
            failures++; $display("FAIL drain_head1 got=%h/%h cnt%0d exp=bfc00004/24090002 cnt1", addr_out, inst_out, count);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0 || count !== 2'd0) begin
            failures++; $display("FAIL drain_empty got=v%0b cnt%0d exp=v0 cnt0", valid_out, count);
        end
    endtask

    task automatic test_full_pop_push();
        ready_in = 1'b0;
        drive(1'b1, 32'h0000_1000, 32'hAAAA_0001);
        tick();
        drive(1'b1, 32'h0000_1004, 32'hAAAA_0002);
        tick();
        ready_in = 1'b1;
        drive(1'b1, 32'h0000_1008, 32'hAAAA_0003);
        tick();
        checks++;
        if (count !== 2'd1 || addr_out !== 32'h0000_1004) begin
            failures++; $display("FAIL full_pop_push got=cnt%0d %h exp=cnt1 00001004", count, addr_out);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (count !== 2'd0 || valid_out !== 1'b0) begin
            failures++; $display("FAIL full_refused_gone got=cnt%0d v%0b exp=cnt0 v0", count, valid_out);
        end
    endtask

    task automatic test_flush();
        ready_in = 1'b0;
        drive(1'b1, 32'h0000_2000, 32'hBBBB_0001);
        tick();
        drive(1'b1, 32'h0000_2004, 32'hBBBB_0002);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h0000_2008, 32'hBBBB_0003);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (count !== 2'd0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
            failures++; $display("FAIL flush_clear got=cnt%0d v%0b r%0b exp=cnt0 v0 r1", count, valid_out, ready_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0 || count !== 2'd0) begin
            failures++; $display("FAIL flush_dropped got=v%0b cnt%0d exp=v0 cnt0", valid_out, count);
        end
    endtask

    // Streams five pairs with ready_in high; pointers wrap more than once.
    task automatic test_back_to_back();
        ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0000_3000 + 32'(k * 4), 32'hCC00_0000 + 32'(k));
`ifdef FDB_BYPASS_EN
            #1;
            checks++;
            if (valid_out !== 1'b1 || addr_out !== 32'h0000_3000 + 32'(k * 4) || count !== 2'd0) begin
                failures++; $display("FAIL stream_%0d got=v%0b %h cnt%0d exp=v1 %h cnt0", k, valid_out, addr_out, count, 32'h0000_3000 + 32'(k * 4));
            end
            tick();
`else
            tick();
            checks++;
            if (valid_out !== 1'b1 || addr_out !== 32'h0000_3000 + 32'(k * 4) ||
                inst_out !== 32'hCC00_0000 + 32'(k) || count !== 2'd1) begin
                failures++; $display("FAIL stream_%0d got=v%0b %h/%h cnt%0d exp=v1 %h cnt1", k, valid_out, addr_out, inst_out, count, 32'h0000_3000 + 32'(k * 4));
            end
`endif
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (count !== 2'd0 || valid_out !== 1'b0) begin
            failures++; $display("FAIL stream_end got=cnt%0d v%0b exp=cnt0 v0", count, valid_out);
        end
    endtask

    task automatic test_bypass();
        ready_in = 1'b1;
        drive(1'b1, 32'h8000_0010, 32'h0000_0020);
        #1;
`ifdef FDB_BYPASS_EN
        checks++;
        if (valid_out !== 1'b1 || addr_out !== 32'h8000_0010 || count !== 2'd0) begin
            failures++; $display("FAIL bypass_same got=v%0b %h cnt%0d exp=v1 80000010 cnt0", valid_out, addr_out, count);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (count !== 2'd0 || valid_out !== 1'b0) begin
            failures++; $display("FAIL bypass_nostore got=cnt%0d v%0b exp=cnt0 v0", count, valid_out);
        end
`else
        checks++;
        if (valid_out !== 1'b0) begin
            failures++; $display("FAIL nobypass_same got=v%0b exp=v0", valid_out);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (valid_out !== 1'b1 || addr_out !== 32'h8000_0010 || count !== 2'd1) begin
            failures++; $display("FAIL nobypass_next got=v%0b %h cnt%0d exp=v1 80000010 cnt1", valid_out, addr_out, count);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        ready_in = 1'b0;
        drive(1'b1, 32'h0000_4000, 32'hDDDD_0001);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (count !== 2'd0 || valid_out !== 1'b0 || addr_out !== 32'h0 || inst_out !== 32'h0) begin
            failures++; $display("FAIL reset_mid got=cnt%0d v%0b %h/%h exp=cnt0 v0 0/0", count, valid_out, addr_out, inst_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_pop_push();
        test_flush();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
